// File: rtl/dmem_lane_arbiter.sv
// dmem_lane_arbiter
//   Shares the single data-memory port between issue lane 0 (older) and
//   lane 1 (younger) at the MEM stage of the dual-issue core. When both lanes
//   access memory in the same cycle, lane 0 goes first, the pipeline is stalled
//   for one cycle, and lane 1 is serviced in the following (SECOND) cycle.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   flush_i                  pipeline flush; aborts a pending lane 1 access
//   mem_write0_i/mem_read0_i lane 0 store/load op (0 = none), addr0_i, wdata0_i
//   mem_write1_i/mem_read1_i lane 1 store/load op (0 = none), addr1_i, wdata1_i
//   mem_write_o/mem_read_o   port store/load op, mem_addr_o, mem_wdata_o
//   mem_rdata_i              port load data, valid the cycle after a read
//   rdata0_o/rdata1_o        per-lane load results
//   stall_o                  holds F/D/E/M this cycle
//   grant_o                  one-hot lane owning the port (00 = idle)
//
// Optional feature (macro DMEM_ARB_STATS_EN):
//   conflict_cnt_o           saturating count of IDLE->SECOND transitions
module dmem_lane_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [OPW-1:0]  mem_write0_i,
  input  logic [OPW-1:0]  mem_read0_i,
  input  logic [XLEN-1:0] addr0_i,
  input  logic [XLEN-1:0] wdata0_i,
  input  logic [OPW-1:0]  mem_write1_i,
  input  logic [OPW-1:0]  mem_read1_i,
  input  logic [XLEN-1:0] addr1_i,
  input  logic [XLEN-1:0] wdata1_i,
  output logic [OPW-1:0]  mem_write_o,
  output logic [OPW-1:0]  mem_read_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] rdata0_o,
  output logic [XLEN-1:0] rdata1_o,
  output logic            stall_o,
  output logic [1:0]      grant_o
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]     conflict_cnt_o
`endif
);

  typedef enum logic {
    IDLE,
    SECOND
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      rsel_q, rsel_d;
  logic [XLEN-1:0] hold0_q, hold0_d;
  logic [XLEN-1:0] hold1_q, hold1_d;

  logic            acc0, acc1, conflict;
  logic [OPW-1:0]  rd0_eff, rd1_eff;
  logic            sel0, sel1;
  logic            stall_raw;

  // A store and a load on the same lane: the store wins, the load is dropped.
  always_comb begin
    rd0_eff  = (|mem_write0_i) ? '0 : mem_read0_i;
    rd1_eff  = (|mem_write1_i) ? '0 : mem_read1_i;
    acc0     = (|mem_write0_i) | (|mem_read0_i);
    acc1     = (|mem_write1_i) | (|mem_read1_i);
    conflict = acc0 & acc1;
  end

  // Next-state and lane selection.
  always_comb begin
    state_d   = state_q;
    sel0      = 1'b0;
    sel1      = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          sel0      = 1'b1;
          stall_raw = 1'b1;
          if (!flush_i) begin
            state_d = SECOND;
          end
        end else if (acc0) begin
          sel0 = 1'b1;
        end else if (acc1) begin
          sel1 = 1'b1;
        end
      end
      SECOND: begin
        // Pipeline is holding its inputs, so lane 1 is still presented.
        state_d = IDLE;
        sel1    = ~flush_i;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port mux and handshake outputs.
  always_comb begin
    mem_write_o = '0;
    mem_read_o  = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel0) begin
      mem_write_o = mem_write0_i;
      mem_read_o  = rd0_eff;
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
    end else if (sel1) begin
      mem_write_o = mem_write1_i;
      mem_read_o  = rd1_eff;
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
    end
    stall_o = stall_raw & ~rst;
    grant_o = rst ? 2'b00 : {sel1, sel0};
  end

  // Read return tracking: rsel marks the lane whose load data arrives next cycle.
  always_comb begin
    rsel_d  = {sel1 & (|rd1_eff), sel0 & (|rd0_eff)};
    hold0_d = rsel_q[0] ? mem_rdata_i : hold0_q;
    hold1_d = rsel_q[1] ? mem_rdata_i : hold1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rsel_q  <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

  always_comb begin
    rdata0_o = rsel_q[0] ? mem_rdata_i : hold0_q;
    rdata1_o = rsel_q[1] ? mem_rdata_i : hold1_q;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q == IDLE) && (state_d == SECOND) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Testbench for dmem_lane_arbiter: directed scenarios followed by randomized
// instruction pairs. The driver derives expected port activity and load results
// from a transaction-level memory model and queues them; a monitor compares
// them against the DUT every cycle.
module tb_dmem_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [2:0]  mem_write0_i = '0, mem_read0_i = '0;
  logic [31:0] addr0_i = '0, wdata0_i = '0;
  logic [2:0]  mem_write1_i = '0, mem_read1_i = '0;
  logic [31:0] addr1_i = '0, wdata1_i = '0;
  logic [2:0]  mem_write_o, mem_read_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] rdata0_o, rdata1_o;
  logic        stall_o;
  logic [1:0]  grant_o;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_cnt_o;
`endif

  dmem_lane_arbiter #(.XLEN(32), .OPW(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .mem_write0_i(mem_write0_i), .mem_read0_i(mem_read0_i),
    .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .mem_write1_i(mem_write1_i), .mem_read1_i(mem_read1_i),
    .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .stall_o(stall_o), .grant_o(grant_o)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory behind the port: one-cycle read latency.
  logic [31:0] env_mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_write_o != 3'd0) env_mem[mem_addr_o] = mem_wdata_o;
    else if (mem_read_o != 3'd0)
      mem_rdata_i <= env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : 32'd0;
  end

  // Reference: program-ordered memory and expected traffic.
  typedef struct {
    int          cyc;
    logic [2:0]  w, r;
    logic [31:0] a, d;
    logic [1:0]  g;
    logic        s;
  } port_t;
  typedef struct {
    int          lane;
    logic [31:0] val;
    int          due;
  } rd_t;

  logic [31:0] ref_mem [logic [31:0]];
  port_t       port_q[$];
  rd_t         rd_q[$];
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  int          exp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    env_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [2:0] w, input logic [2:0] r, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] g, input logic s);
    port_t e;
    e.cyc = cyc; e.w = w; e.r = (w != 3'd0) ? 3'd0 : r; e.a = a; e.d = d; e.g = g; e.s = s;
    port_q.push_back(e);
  endtask

  // Lane access takes effect in program order in the reference memory.
  task automatic apply(input int lane, input logic [2:0] w, input logic [2:0] r, input logic [31:0] a,
                       input logic [31:0] d);
    rd_t e;
    if (w != 3'd0) ref_mem[a] = d;
    else if (r != 3'd0) begin
      e.lane = lane; e.val = ref_rd(a); e.due = cyc + 1;
      rd_q.push_back(e);
    end
  endtask

  task automatic set_lanes(input logic [2:0] w0, input logic [2:0] r0, input logic [31:0] a0,
                           input logic [31:0] d0, input logic [2:0] w1, input logic [2:0] r1,
                           input logic [31:0] a1, input logic [31:0] d1);
    mem_write0_i = w0; mem_read0_i = r0; addr0_i = a0; wdata0_i = d0;
    mem_write1_i = w1; mem_read1_i = r1; addr1_i = a1; wdata1_i = d1;
  endtask

  task automatic idle_cycle(input logic r);
    tick();
    rst = r;
    flush_i = 1'b0;
    set_lanes('0, '0, '0, '0, '0, '0, '0, '0);
    push_exp('0, '0, '0, '0, 2'b00, 1'b0);
  endtask

  // One instruction pair; fa = flush in the first cycle, fb = flush in SECOND.
  task automatic do_pair(input logic [2:0] w0, input logic [2:0] r0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [2:0] w1, input logic [2:0] r1,
                         input logic [31:0] a1, input logic [31:0] d1, input logic fa,
                         input logic fb);
    logic acc0, acc1;
    acc0 = (w0 != 3'd0) || (r0 != 3'd0);
    acc1 = (w1 != 3'd0) || (r1 != 3'd0);
    tick();
    rst = 1'b0;
    flush_i = fa;
    set_lanes(w0, r0, a0, d0, w1, r1, a1, d1);
    if (acc0 && acc1) begin
      push_exp(w0, r0, a0, d0, 2'b01, 1'b1);
      apply(0, w0, r0, a0, d0);
      if (!fa) begin
        exp_cnt++;
        tick();
        flush_i = fb;
        if (fb) push_exp('0, '0, '0, '0, 2'b00, 1'b0);
        else begin
          push_exp(w1, r1, a1, d1, 2'b10, 1'b0);
          apply(1, w1, r1, a1, d1);
        end
      end
    end else if (acc0) begin
      push_exp(w0, r0, a0, d0, 2'b01, 1'b0);
      apply(0, w0, r0, a0, d0);
    end else if (acc1) begin
      push_exp(w1, r1, a1, d1, 2'b10, 1'b0);
      apply(1, w1, r1, a1, d1);
    end else begin
      push_exp('0, '0, '0, '0, 2'b00, 1'b0);
    end
  endtask

  // Monitor: compares port traffic and per-lane load results every cycle.
  initial begin
    port_t e;
    rd_t   r;
    forever begin
      @(negedge clk);
      if (cyc != 0) begin
        if (rst) begin
          rd_q.delete();
          exp_rd0 = '0;
          exp_rd1 = '0;
        end
        if (port_q.size() != 0 && port_q[0].cyc == cyc) begin
          e = port_q.pop_front();
          chk("port{w,r,addr,wdata,grant,stall}",
              {55'd0, mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, grant_o, stall_o},
              {55'd0, e.w, e.r, e.a, e.d, e.g, e.s});
        end
        while (rd_q.size() != 0 && rd_q[0].due == cyc) begin
          r = rd_q.pop_front();
          if (r.lane == 0) exp_rd0 = r.val;
          else exp_rd1 = r.val;
        end
        chk("rdata0", {96'd0, rdata0_o}, {96'd0, exp_rd0});
        chk("rdata1", {96'd0, rdata1_o}, {96'd0, exp_rd1});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] rand_op();
    return ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
  endfunction

  initial begin
    // Reset state.
    repeat (3) idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Single lane 0 load.
    preload(32'h8000_0010, 32'hDEAD_BEEF);
    do_pair(3'd0, 3'd2, 32'h8000_0010, 32'd0, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Lane 0 store then lane 1 load of the same address.
    do_pair(3'd2, 3'd0, 32'h8000_0020, 32'h1234_5678, 3'd0, 3'd2, 32'h8000_0020, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Both lanes load.
    preload(32'h8000_0000, 32'h11);
    preload(32'h8000_0004, 32'h22);
    do_pair(3'd0, 3'd2, 32'h8000_0000, 32'd0, 3'd0, 3'd2, 32'h8000_0004, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // Flush in SECOND drops the lane 1 store.
    preload(32'h8000_0030, 32'hAAAA);
    do_pair(3'd0, 3'd2, 32'h8000_0004, 32'd0, 3'd2, 3'd0, 32'h8000_0030, 32'h5555, 1'b0, 1'b1);
    do_pair(3'd0, 3'd2, 32'h8000_0030, 32'd0, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Back-to-back conflicts, store-with-load on lane 0, then a flush in IDLE.
    do_pair(3'd2, 3'd5, 32'h8000_0008, 32'hCAFE, 3'd0, 3'd4, 32'h8000_0008, 32'd0, 1'b0, 1'b0);
    do_pair(3'd0, 3'd1, 32'h8000_0008, 32'd0, 3'd3, 3'd0, 32'h8000_0008, 32'hF00D, 1'b0, 1'b0);
    do_pair(3'd0, 3'd1, 32'h8000_0008, 32'd0, 3'd1, 3'd0, 32'h8000_000C, 32'hBAD, 1'b1, 1'b0);
    do_pair(3'd0, 3'd2, 32'h8000_000C, 32'd0, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    chk("conflict_cnt", {96'd0, conflict_cnt_o}, 128'(exp_cnt));
`endif

    // Reset pulsed during SECOND: lane 1 store never issued, holds cleared.
    preload(32'h8000_0018, 32'h7777);
    tick();
    rst = 1'b0; flush_i = 1'b0;
    set_lanes(3'd0, 3'd2, 32'h8000_0018, 32'd0, 3'd2, 3'd0, 32'h8000_0018, 32'h9999);
    push_exp(3'd0, 3'd2, 32'h8000_0018, 32'd0, 2'b01, 1'b1);
    apply(0, 3'd0, 3'd2, 32'h8000_0018, 32'd0);
    idle_cycle(1'b1);
    exp_cnt = 0;
    idle_cycle(1'b0);
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    chk("conflict_cnt_after_reset", {96'd0, conflict_cnt_o}, 128'd0);
`endif
    do_pair(3'd0, 3'd2, 32'h8000_0018, 32'd0, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Randomized pairs.
    for (int i = 0; i < 300; i++) begin
      do_pair(rand_op(), rand_op(), rand_addr(), $urandom, rand_op(), rand_op(), rand_addr(), $urandom,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'b0);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    chk("conflict_cnt_final", {96'd0, conflict_cnt_o}, 128'(exp_cnt));
`endif

    @(negedge clk);
    #1;
    chk("pending_port_expectations", 128'(port_q.size()), 128'd0);
    chk("pending_read_expectations", 128'(rd_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
